// File: rtl/ofm_readback_streamer.sv
// ofm_readback_streamer: reads a finished OFM back from the OFM RAM in linear address order
// and presents it as a valid/ready stream of INOUT_WIDTH beats with per-element keep.
// Latency: start -> CHECK -> read issue -> data return, so the first out_valid comes 3 cycles after start.
// Backpressure: at most 2 beats are ever owned (skid FIFO + read in flight); reads pause while out_ready is low.
// Ports: start/ofm_size/num_filter configure a run; rd_en/rd_addr/rd_data drive the RAM read port;
//        out_valid/out_ready/out_data/out_keep/out_last carry the stream; busy/done/err report status.
// Optional build macro OFM_READBACK_CHECKSUM_EN adds output checksum[31:0] (sum of kept elements).
module ofm_readback_streamer #(
    parameter int DATA_WIDTH   = 16,
    parameter int INOUT_WIDTH  = 256,
    parameter int ADDR_WIDTH   = 20,
    parameter int OFM_RAM_SIZE = 692224
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [8:0]                          ofm_size,
    input  logic [10:0]                         num_filter,
    output logic                                rd_en,
    output logic [ADDR_WIDTH-1:0]               rd_addr,
    input  logic [INOUT_WIDTH-1:0]              rd_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [INOUT_WIDTH-1:0]              out_data,
    output logic [INOUT_WIDTH/DATA_WIDTH-1:0]   out_keep,
    output logic                                out_last,
    output logic                                busy,
    output logic                                done,
    output logic                                err
`ifdef OFM_READBACK_CHECKSUM_EN
    ,
    output logic [31:0]                         checksum
`endif
);

    localparam int E     = INOUT_WIDTH / DATA_WIDTH;
    localparam int LOG2E = $clog2(E);

    typedef enum logic [1:0] {IDLE, CHECK, STREAM, FINISH} state_t;

    state_t                   state_q, state_d;
    logic [30:0]              total_q;
    logic [30:0]              rd_cnt_q;
    logic [30:0]              out_cnt_q;
    logic [ADDR_WIDTH-1:0]    rd_addr_q;
    logic                     inflight_q;
    logic                     err_q;
    logic [INOUT_WIDTH-1:0]   mem_q [2];
    logic                     wr_ptr_q, rd_ptr_q;
    logic [1:0]               count_q;

    logic [30:0]              beats;
    logic                     last_beat;
    logic                     accept, push, pop, start_acc;
    logic [E-1:0]             last_keep;
    logic [LOG2E-1:0]         rem;

    assign start_acc = (state_q == IDLE) && start;
    assign beats     = (total_q + 31'(E - 1)) >> LOG2E;
    assign last_beat = (out_cnt_q == beats - 31'd1);
    assign rem       = total_q[LOG2E-1:0];

    // The head beat is the FIFO head when it holds data, otherwise the RAM word
    // arriving this cycle falls straight through so one beat/cycle is sustained.
    assign out_valid = (count_q != 2'd0) || inflight_q;
    assign accept    = out_valid && out_ready;
    assign pop       = (count_q != 2'd0) && out_ready;
    assign push      = inflight_q && !((count_q == 2'd0) && out_ready);

    assign rd_en   = (state_q == STREAM) && (rd_cnt_q < beats) &&
                     ((count_q + {1'b0, inflight_q}) < 2'd2);
    assign rd_addr = rd_addr_q;

    always_comb begin
        last_keep = '0;
        for (int k = 0; k < E; k++) begin
            last_keep[k] = (rem == '0) || (LOG2E'(k) < rem);
        end
    end

    assign out_data = (count_q != 2'd0) ? mem_q[rd_ptr_q] : (inflight_q ? rd_data : '0);
    assign out_keep = !out_valid ? '0 : (last_beat ? last_keep : '1);
    assign out_last = out_valid && last_beat;
    assign busy     = (state_q == CHECK) || (state_q == STREAM);
    assign done     = (state_q == FINISH);
    assign err      = err_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CHECK;
            CHECK: begin
                if (total_q == 31'd0 || total_q > 31'(OFM_RAM_SIZE)) state_d = FINISH;
                else                                                 state_d = STREAM;
            end
            STREAM:  if (accept && last_beat) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            total_q    <= '0;
            rd_cnt_q   <= '0;
            out_cnt_q  <= '0;
            rd_addr_q  <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            inflight_q <= rd_en;
            if (start_acc) begin
                total_q   <= 31'(ofm_size) * 31'(ofm_size) * 31'(num_filter);
                rd_cnt_q  <= '0;
                out_cnt_q <= '0;
                rd_addr_q <= '0;
                err_q     <= 1'b0;
            end
            if (state_q == CHECK && total_q > 31'(OFM_RAM_SIZE)) err_q <= 1'b1;
            if (rd_en) begin
                rd_cnt_q  <= rd_cnt_q + 31'd1;
                rd_addr_q <= rd_addr_q + ADDR_WIDTH'(E);
            end
            if (accept) out_cnt_q <= out_cnt_q + 31'd1;
            if (push) begin
                mem_q[wr_ptr_q] <= rd_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef OFM_READBACK_CHECKSUM_EN
    logic [31:0] sum_q, beat_sum;

    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < E; k++) begin
            if (out_keep[k]) beat_sum = beat_sum + 32'($signed(out_data[k*DATA_WIDTH +: DATA_WIDTH]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          sum_q <= '0;
        else if (start_acc)  sum_q <= '0;
        else if (accept)     sum_q <= sum_q + beat_sum;
    end

    assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_ofm_readback_streamer.sv
module tb_ofm_readback_streamer;
    localparam int DW = 16;
    localparam int IW = 256;
    localparam int AW = 20;
    localparam int E  = IW / DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [8:0]    ofm_size = '0;
    logic [10:0]   num_filter = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [IW-1:0] rd_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [IW-1:0] out_data;
    logic [E-1:0]  out_keep;
    logic          out_last;
    logic          busy, done, err;
`ifdef OFM_READBACK_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    ofm_readback_streamer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ofm_size(ofm_size), .num_filter(num_filter),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
        .out_last(out_last), .busy(busy), .done(done), .err(err)
`ifdef OFM_READBACK_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  n_tests = 0, n_fail = 0;
    bit  ram_ones = 1'b0;
    bit  rand_mode = 1'b0;

    // RAM model: word w holds a per-lane pattern (or all -1 when ram_ones is set).
    function automatic logic [IW-1:0] mk_word(input int w);
        logic [IW-1:0] r;
        r = '0;
        for (int k = 0; k < E; k++) r[k*DW +: DW] = ram_ones ? 16'hFFFF : 16'(w * 37 + k * 3 + 5);
        return r;
    endfunction

    always @(posedge clk) if (rd_en) rd_data <= mk_word(int'(rd_addr) / E);

    task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard state
    logic [IW-1:0] q_data[$];
    logic [E-1:0]  q_keep[$];
    bit            q_last[$];
    int            reads_issued = 0, acc_cnt = 0, done_cnt = 0, done_cyc = 0, last_acc_cyc = 0;
    bit            done_flag = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    bit            prev_stall = 1'b0;
    logic [IW-1:0] prev_data;
    logic [E-1:0]  prev_keep;
    logic          prev_last;

    // ready driver
    initial forever begin
        @(posedge clk);
        #1 out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // monitor
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_data", out_data, prev_data);
                chk("stall_ctl", IW'({out_valid, out_last, out_keep}), IW'({1'b1, prev_last, prev_keep}));
            end
            if (rd_en) begin
                chk("rd_addr", IW'(rd_addr), IW'(exp_addr));
                chk("outstanding_le2", IW'((reads_issued + 1 - acc_cnt) <= 2), IW'(1));
                reads_issued++;
                exp_addr = exp_addr + AW'(E);
            end
            if (out_valid && out_ready) begin
                if (q_data.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_beat: got beat %h expected none", out_data);
                end else begin
                    chk("beat_data", out_data, q_data.pop_front());
                    chk("beat_keep", IW'(out_keep), IW'(q_keep.pop_front()));
                    chk("beat_last", IW'(out_last), IW'(q_last.pop_front()));
                end
                acc_cnt++;
                last_acc_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_keep  = out_keep;
            prev_last  = out_last;
            if (done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_flag = 1'b1;
                chk("busy_at_done", IW'(busy), IW'(0));
            end
        end
    end

    task automatic clear_sb();
        q_data.delete();
        q_keep.delete();
        q_last.delete();
        reads_issued = 0;
        acc_cnt      = 0;
        exp_addr     = '0;
        done_flag    = 1'b0;
    endtask

    task automatic push_expected(input int beats, input logic [E-1:0] last_keep);
        for (int i = 0; i < beats; i++) begin
            q_data.push_back(mk_word(i));
            q_keep.push_back((i == beats - 1) ? last_keep : 16'hFFFF);
            q_last.push_back(i == beats - 1);
        end
    endtask

    task automatic pulse_start(input int sz, input int nf, output int t0);
        @(posedge clk);
        #1 start = 1'b1;
        ofm_size   = 9'(sz);
        num_filter = 11'(nf);
        t0 = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // exp_lat: done cycle relative to the start cycle (0 = not checked)
    task automatic run(input int sz, input int nf, input int beats, input logic [E-1:0] last_keep,
                       input bit rnd, input int exp_lat, input bit exp_err, input bit mid_start);
        int t0, tmp, dc0;
        rand_mode = rnd;
        clear_sb();
        push_expected(beats, last_keep);
        dc0 = done_cnt;
        pulse_start(sz, nf, t0);
        if (mid_start) begin
            repeat (20) @(posedge clk);
            #1 chk("busy_mid", IW'(busy), IW'(1));
            pulse_start(3, 1, tmp);
        end
        for (int i = 0; i < 6000 && !done_flag; i++) @(posedge clk);
        #1;
        if (!done_flag) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done for size=%0d nf=%0d", sz, nf);
        end else begin
            chk("err", IW'(err), IW'(exp_err));
            chk("reads_issued", IW'(reads_issued), IW'(beats));
            chk("beats_left", IW'(q_data.size()), IW'(0));
            if (exp_lat > 0) chk("done_latency", IW'(done_cyc - t0), IW'(exp_lat));
            if (beats > 0) chk("done_after_last", IW'(done_cyc - last_acc_cyc), IW'(1));
        end
        repeat (3) @(posedge clk);
        #1 chk("one_done", IW'(done_cnt - dc0), IW'(1));
        rand_mode = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, dc0;
        repeat (3) @(posedge clk);
        chk("reset_ctl", IW'({out_valid, rd_en, busy, done, err, out_last, out_keep}), IW'(0));
        chk("reset_data", out_data, IW'(0));
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("idle_ctl", IW'({out_valid, rd_en, busy, done, err, rd_addr}), IW'(0));

        run(16, 16, 256, 16'hFFFF, 1'b0, 259, 1'b0, 1'b0);
        run(5,  1,  2,   16'h01FF, 1'b0, 5,   1'b0, 1'b0);
        run(3,  3,  2,   16'h07FF, 1'b0, 5,   1'b0, 1'b0);
        run(511, 2047, 0, 16'hFFFF, 1'b0, 2,  1'b1, 1'b0);
        run(0,  16, 0,   16'hFFFF, 1'b0, 2,   1'b0, 1'b0);
        run(17, 16, 289, 16'hFFFF, 1'b1, 0,   1'b0, 1'b1);

        // abort a 256-beat run with reset after beat 10
        clear_sb();
        push_expected(256, 16'hFFFF);
        dc0 = done_cnt;
        pulse_start(16, 16, t0);
        for (int i = 0; i < 200 && acc_cnt < 10; i++) @(posedge clk);
        chk("reached_beat10", IW'(acc_cnt >= 10), IW'(1));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("abort_ctl", IW'({out_valid, rd_en, busy, done, err, out_last, out_keep}), IW'(0));
        chk("abort_data", out_data, IW'(0));
        chk("abort_addr", IW'(rd_addr), IW'(0));
        clear_sb();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("abort_no_done", IW'(done_cnt - dc0), IW'(0));
        run(16, 16, 256, 16'hFFFF, 1'b0, 259, 1'b0, 1'b0);

`ifdef OFM_READBACK_CHECKSUM_EN
        ram_ones = 1'b1;
        run(5, 1, 2, 16'h01FF, 1'b0, 5, 1'b0, 1'b0);
        chk("checksum", IW'(checksum), IW'(32'hFFFFFFE7));
        ram_ones = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
